video_fetch: RTL and testbench

//  Video-side client of the time-multiplexed SRAM controller. Supplies the video word address and

---
 rtl/vid_pkg.sv | 14 +
 rtl/vfifo.sv | 61 ++++++
 rtl/video_fetch.sv | 87 ++++++++
 tb/tb_video_fetch.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/vid_pkg.sv
// Shared defaults and state encoding for the video fetch path.
package vid_pkg;

    localparam int DEF_AW    = 18;
    localparam int DEF_DW    = 16;
    localparam int DEF_WPL   = 80;
    localparam int DEF_DEPTH = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } state_t;

endpackage

// File: rtl/vfifo.sv
// Small synchronous FIFO with flush and a registered head word.
module vfifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [DW-1:0]          din,
    input  logic                   pop,
    input  logic                   flush,
    output logic [DW-1:0]          dout,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [DW-1:0] head;
    logic          do_pop;

    assign do_pop = pop && (count != '0);
    assign valid  = (count != '0);
    assign dout   = head;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            if (rst)
                head <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !do_pop)
                count <= count + 1'b1;
            else if (!push && do_pop)
                count <= count - 1'b1;
            // head tracks the oldest word; when draining the last one the new push takes over
            if (count == '0 || (do_pop && count == CW'(1))) begin
                if (push)
                    head <= din;
            end else if (do_pop) begin
                head <= mem[rd_ptr + 1'b1];
            end
        end
    end

endmodule

// File: rtl/video_fetch.sv
// Video-side SRAM client: issues word addresses on video slots and
// buffers returned words for the pixel serializer.
module video_fetch
    import vid_pkg::*;
#(
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW,
    parameter int WPL   = DEF_WPL,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic          mclk,
    input  logic          rst,
    input  logic          mc,
    input  logic          line_start,
    input  logic [AW-1:0] line_base,
    input  logic [DW-1:0] sram_dq,
    output logic [AW-1:0] vaddr,
    output logic [DW-1:0] pix_data,
    output logic          pix_valid,
    input  logic          pix_rd,
    output logic          busy,
    output logic          underrun
);

    localparam int RW = $clog2(WPL + 1);
    localparam int CW = $clog2(DEPTH) + 1;

    state_t        state;
    logic [RW-1:0] remaining;
    logic          inflight;
    logic [CW-1:0] fcount;
    logic [CW:0]   fill;
    logic          issue_ok;
    logic          capture;

    assign fill     = {1'b0, fcount} + {{CW{1'b0}}, inflight};
    assign issue_ok = (state == ST_FETCH)
                   && (remaining > RW'(inflight))
                   && (fill < (CW+1)'(DEPTH));
    // line_start wins over a capture landing on the same edge
    assign capture  = mc && inflight && !line_start;
    assign busy     = (state == ST_FETCH);

    always_ff @(posedge mclk) begin
        if (rst) begin
            state     <= ST_IDLE;
            vaddr     <= '0;
            remaining <= '0;
            inflight  <= 1'b0;
            underrun  <= 1'b0;
        end else if (line_start) begin
            state     <= ST_FETCH;
            vaddr     <= line_base;
            remaining <= RW'(WPL);
            inflight  <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            if (pix_rd && !pix_valid)
                underrun <= 1'b1;
            if (!mc) begin
                inflight <= issue_ok;
            end else if (inflight) begin
                vaddr     <= vaddr + 1'b1;
                remaining <= remaining - 1'b1;
                inflight  <= 1'b0;
                if (remaining == RW'(1))
                    state <= ST_IDLE;
            end
        end
    end

    vfifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (mclk),
        .rst   (rst),
        .push  (capture),
        .din   (sram_dq),
        .pop   (pix_rd),
        .flush (line_start),
        .dout  (pix_data),
        .valid (pix_valid),
        .count (fcount)
    );

endmodule

// File: tb/tb_video_fetch.sv
// Scoreboard bench for video_fetch against a slot-accurate SRAM model.
module tb_video_fetch;

    logic        mclk = 1'b0;
    logic        rst = 1'b1;
    logic        mc = 1'b0;
    logic        line_start = 1'b0;
    logic [17:0] line_base = '0;
    logic [15:0] sram_dq = '0;
    logic [17:0] vaddr;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_rd = 1'b0;
    logic        busy;
    logic        underrun;

    int n_pass = 0;
    int n_tot  = 0;
    logic [15:0] exp_q [$];

    video_fetch #(
        .AW(18), .DW(16), .WPL(80), .DEPTH(8)
    ) dut (
        .mclk       (mclk),
        .rst        (rst),
        .mc         (mc),
        .line_start (line_start),
        .line_base  (line_base),
        .sram_dq    (sram_dq),
        .vaddr      (vaddr),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_rd     (pix_rd),
        .busy       (busy),
        .underrun   (underrun)
    );

    always #5 mclk = ~mclk;

    function automatic logic [15:0] mem_word(input logic [17:0] a);
        return a[15:0] ^ {a[17:16], 14'h0} ^ 16'h5A5A;
    endfunction

    // SRAM model: address taken on mc==0 edge, data held through the mc==1 edge
    always @(posedge mclk) begin
        if (!mc)
            sram_dq <= mem_word(vaddr);
        mc <= ~mc;
    end

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] want);
        n_tot++;
        if (got === want)
            n_pass++;
        else
            $display("FAIL %s: got %h want %h", nm, got, want);
    endtask

    // monitor: every accepted pop must match the head of the scoreboard
    always @(negedge mclk) begin
        if (!rst && pix_rd && pix_valid) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected", {16'h0, pix_data}, 32'hFFFF_FFFF);
            end else begin
                check("pix_data", {16'h0, pix_data},
                      {16'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic cyc();
        @(posedge mclk);
        #1;
    endtask

    task automatic start_line(input logic [17:0] base);
        pix_rd = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 80; i++)
            exp_q.push_back(mem_word(base + 18'(i)));
        line_base  = base;
        line_start = 1'b1;
        cyc();
        line_start = 1'b0;
    endtask

    task automatic wait_vaddr(input logic [17:0] a, input int budget,
                              input string nm);
        int n = 0;
        while (vaddr !== a && n < budget) begin
            cyc();
            n++;
        end
        check(nm, {14'h0, vaddr}, {14'h0, a});
    endtask

    task automatic pop_n(input int cnt, input int budget);
        int got = 0;
        int n = 0;
        while (got < cnt && n < budget) begin
            if (pix_valid && !pix_rd) begin
                pix_rd = 1'b1;
                got++;
            end else begin
                pix_rd = 1'b0;
            end
            cyc();
            n++;
        end
        pix_rd = 1'b0;
        check("pop_count", got, cnt);
    endtask

    initial begin
        int pops;
        int n;
        repeat (3) cyc();
        check("rst_vaddr", {14'h0, vaddr}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_valid", {31'h0, pix_valid}, 32'h0);
        check("rst_underrun", {31'h0, underrun}, 32'h0);
        rst = 1'b0;
        cyc();

        // fill to depth, then single-pop refill
        start_line(18'h00100);
        check("t1_busy", {31'h0, busy}, 32'h1);
        check("t1_vaddr0", {14'h0, vaddr}, 32'h100);
        wait_vaddr(18'h00104, 20, "t1_vaddr4");
        repeat (40) cyc();
        check("t2_hold", {14'h0, vaddr}, 32'h108);
        check("t2_valid", {31'h0, pix_valid}, 32'h1);
        check("t2_busy", {31'h0, busy}, 32'h1);
        pop_n(1, 10);
        repeat (10) cyc();
        check("t2_one_more", {14'h0, vaddr}, 32'h109);
        pop_n(3, 20);
        repeat (12) cyc();
        check("t2_three_more", {14'h0, vaddr}, 32'h10C);
        check("t2_no_underrun", {31'h0, underrun}, 32'h0);

        // address wrap
        start_line(18'h3FFFE);
        repeat (30) cyc();
        check("t3_wrap", {14'h0, vaddr}, 32'h6);
        pop_n(4, 20);

        // abort while a word is inflight
        start_line(18'h00100);
        wait_vaddr(18'h00103, 20, "t4_three");
        n = 0;
        while (mc !== 1'b1 && n < 4) begin
            cyc();
            n++;
        end
        start_line(18'h00200);
        check("t4_flushed", {31'h0, pix_valid}, 32'h0);
        check("t4_vaddr", {14'h0, vaddr}, 32'h200);
        pop_n(4, 30);

        // underrun is sticky
        pix_rd = 1'b1;
        repeat (30) cyc();
        pix_rd = 1'b0;
        check("t5_underrun", {31'h0, underrun}, 32'h1);
        repeat (4) cyc();
        check("t5_sticky", {31'h0, underrun}, 32'h1);

        // full line at one pop per two cycles
        start_line(18'h01000);
        check("t5_clear", {31'h0, underrun}, 32'h0);
        pops = 0;
        n = 0;
        while (pops < 80 && n < 400) begin
            if (pix_valid && !pix_rd) begin
                pix_rd = 1'b1;
                pops++;
            end else begin
                pix_rd = 1'b0;
            end
            cyc();
            n++;
        end
        pix_rd = 1'b0;
        repeat (4) cyc();
        check("t6_pops", pops, 80);
        check("t6_queue", exp_q.size(), 0);
        check("t6_busy", {31'h0, busy}, 32'h0);
        check("t6_underrun", {31'h0, underrun}, 32'h0);
        check("t6_empty", {31'h0, pix_valid}, 32'h0);
        check("t6_vaddr", {14'h0, vaddr}, 32'h1050);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
